// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Sequential accumulate stage of the matrix MAC datapath. A job starts with a
// start pulse carrying a length. The block then sums that many signed products
// arriving on a valid/ready stream. It presents the total, plus a sticky signed
// overflow flag, on a second valid/ready handshake.
//
// Optional feature macro: SATURATE_EN
//   defined   - an overflowing add clamps the accumulator to the max/min value.
//   undefined - the accumulator wraps modulo 2^DATA_W (default build).
//   Overflow is flagged identically in both builds.
//
// Ports
//   clk_i        in   1       clock, rising edge
//   reset_i      in   1       asynchronous active-high reset, clears all state
//   start_i      in   1       job start pulse, sampled only in IDLE
//   len_i        in   CNT_W   job length in beats, sampled with start_i
//   in_valid_i   in   1       in_data_i holds a product
//   in_ready_o   out  1       a product can be accepted this cycle
//   in_data_i    in   DATA_W  signed product
//   out_valid_o  out  1       out_data_o / overflow_o hold the finished result
//   out_ready_i  in   1       consumer takes the result
//   out_data_o   out  DATA_W  accumulated sum
//   overflow_o   out  1       sticky signed overflow seen during the job
//   busy_o       out  1       high in every state except IDLE
// -----------------------------------------------------------------------------
module mac_accumulator #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              overflow_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               ovf_q, ovf_d;

    logic               job_start;
    logic               beat_fire;
    logic               last_beat;
    logic [DATA_W-1:0]  sum;
    logic               add_ovf;
    logic [DATA_W-1:0]  acc_next;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign job_start = (state_q == S_IDLE) && start_i;
    assign beat_fire = (state_q == S_ACCUM) && in_valid_i;
    // remaining_q is never 0 while in ACCUM, so 1 marks the final beat.
    assign last_beat = beat_fire && (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1});

    // -------------------------------------------------------------------------
    // Adder stage. Carry out is dropped. Signed overflow happens only when both
    // operands share a sign and the sum's sign differs from it.
    // -------------------------------------------------------------------------
    assign sum     = acc_q + in_data_i;
    assign add_ovf = (acc_q[DATA_W-1] == in_data_i[DATA_W-1]) &&
                     (sum[DATA_W-1]   != acc_q[DATA_W-1]);

`ifdef SATURATE_EN
    // Operands share a sign on overflow, so the accumulator sign picks the clamp.
    always_comb begin
        acc_next = sum;
        if (add_ovf) begin
            acc_next = acc_q[DATA_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        acc_next = sum;
    end

    // The clamp limits are only used by the saturating build.
    logic unused_limits;
    assign unused_limits = ^{ACC_MAX, ACC_MIN};
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // start_i is deliberately not looked at here. A start that
                // coincides with the result handshake is dropped.
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_ACCUM: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state: accumulator, beat counter, sticky overflow
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d       = acc_q;
        remaining_d = remaining_q;
        ovf_d       = ovf_q;
        if (job_start) begin
            acc_d       = '0;
            ovf_d       = 1'b0;
            remaining_d = len_i;
        end else if (beat_fire) begin
            acc_d       = acc_next;
            remaining_d = remaining_q - 1'b1;
            ovf_d       = ovf_q | add_ovf;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q       <= '0;
            remaining_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            ovf_q       <= ovf_d;
        end
    end

    // The accumulator only changes in ACCUM, so it is stable for all of DONE.
    // Reset clears it, so the output also reads 0 after reset.
    assign out_data_o = acc_q;
    assign overflow_o = ovf_q;

endmodule
